fib_stack_ctrl: RTL and testbench
=================================

FIB_STACK_CTRL -- requirements
Module: fib_stack_ctrl

Interface
REQ-001 Parameter: RES_W, default 8, width of result accumulator; must be at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; shared with the 3-bit stack it drives.
REQ-004 start  input  1  request to compute fib(n); sampled only in IDLE.
REQ-005 n  input  3  argument 0..7; captured on the cycle start is accepted.
REQ-006 push  output  1  stack push strobe.
REQ-007 pop  output  1  stack pop strobe.
REQ-008 stk_din  output  3  data written to stack on push.
REQ-009 stk_dout  input  3  stack read data; valid the cycle after a pop edge (registered stack output).
REQ-010 stk_empty  input  1  stack empty flag (combinational from stack pointer).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when result is final.
REQ-013 result  output  RES_W  fib(n); holds last value until next accepted start.

Function
REQ-014 States SHALL be IDLE, PUSH_N, CHECK, WAIT, PUSH2, DONE (binary or one-hot, implementer's choice).
REQ-015 IDLE: start=1 -> latch n, clear accumulator to 0, go PUSH_N; start=0 -> stay.
REQ-016 PUSH_N: push=1, stk_din=latched n; go CHECK.
REQ-017 CHECK: stk_empty=1 -> go DONE (no pop); else pop=1, go WAIT.
REQ-018 WAIT: evaluate stk_dout v: v<2 -> acc<=acc+v, go CHECK; v>=2 -> push=1, stk_din=v-1, latch tmp=v-2, go PUSH2.
REQ-019 PUSH2: push=1, stk_din=tmp; go CHECK.
REQ-020 DONE: done=1, result<=acc (or result driven from acc, equal value), go IDLE.
REQ-021 push and pop SHALL never be asserted in the same cycle; both 0 in IDLE, CHECK-when-empty, DONE.
REQ-022 push/pop/stk_din SHALL be decoded from current state (and stk_dout in WAIT) only; no dependency on start.
REQ-023 Accumulator add SHALL be RES_W wide, unsigned; fib(7)=13 fits with no overflow at RES_W>=4.
REQ-024 start asserted while busy=1 SHALL be ignored; n changes while busy SHALL not affect the computation.
REQ-025 Peak stack occupancy for n=7 SHALL not exceed 7 entries; controller issues no push beyond that.
REQ-026 Controller SHALL finish only when stk_empty=1, leaving the stack empty for the next run.

Reset
REQ-027 On rst=1 (any cycle, including mid-computation): state=IDLE, busy=0, done=0, push=0, pop=0, stk_din=0, result=0, accumulator=0, tmp=0, latched n=0.
REQ-028 After rst deasserts, first start SHALL be accepted on the first rising edge with start=1; stack is assumed reset by the same rst.

Verification
REQ-029 n=0, start 1 cycle -> PUSH_N, CHECK, WAIT, CHECK, DONE; done high exactly 5 cycles after start edge, result=0.
REQ-030 n=1 -> result=1; n=2 -> result=1; n=5 -> result=5; n=7 -> result=13; stack empty at each done.
REQ-031 Back-to-back: n=6 then n=3 with start asserted the cycle after done -> results 8 then 2; result holds 8 until second done.
REQ-032 start pulsed and n changed mid-run of n=4 -> ignored, result=3, single done pulse.
REQ-033 rst asserted in WAIT during n=7 run -> all outputs 0 immediately, busy=0; subsequent n=3 run -> result=2.
REQ-034 Assertion every cycle: !(push && pop); push never while stack holds 7 entries (bench model of depth).

Source files
------------

// File: rtl/fib_stack_ctrl.sv
// Fibonacci controller that evaluates fib(n) by driving an external 3-bit
// stack: each popped argument v < 2 is added to the accumulator, otherwise
// v-1 and v-2 are pushed back. The run ends when the stack drains.
module fib_stack_ctrl #(
  parameter int RES_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       n,
  output logic             push,
  output logic             pop,
  output logic [2:0]       stk_din,
  input  logic [2:0]       stk_dout,
  input  logic             stk_empty,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_N = 3'd1,
    S_CHECK  = 3'd2,
    S_WAIT   = 3'd3,
    S_PUSH2  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_n;
  logic [2:0]       r_tmp;
  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] r_result;
  logic             w_leaf;
  logic [RES_W-1:0] w_dout_ext;

  // A popped value below 2 is a leaf of the recursion tree: fib(v) = v.
  assign w_leaf     = (stk_dout < 3'd2);
  assign w_dout_ext = {{(RES_W-3){1'b0}}, stk_dout};

  // The result is shown from the accumulator during the done pulse so the
  // value is already final while done is high; otherwise the held copy.
  assign result = (r_state == S_DONE) ? r_acc : r_result;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stack-strobe decode from the current state (and stack data in WAIT).
  always_comb begin
    w_state_next = r_state;
    push         = 1'b0;
    pop          = 1'b0;
    stk_din      = 3'd0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = S_PUSH_N;
        end
      end
      S_PUSH_N: begin
        push         = 1'b1;
        stk_din      = r_n;
        w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (stk_empty) begin
          w_state_next = S_DONE;
        end else begin
          pop          = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_leaf) begin
          w_state_next = S_CHECK;
        end else begin
          push         = 1'b1;
          stk_din      = stk_dout - 3'd1;
          w_state_next = S_PUSH2;
        end
      end
      S_PUSH2: begin
        push         = 1'b1;
        stk_din      = r_tmp;
        w_state_next = S_CHECK;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch n on accept, accumulate leaves, park v-2 for the second push, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n      <= 3'd0;
      r_tmp    <= 3'd0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n   <= n;
            r_acc <= '0;
          end
        end
        S_WAIT: begin
          if (w_leaf) begin
            r_acc <= r_acc + w_dout_ext;
          end else begin
            r_tmp <= stk_dout - 3'd2;
          end
        end
        S_DONE: begin
          r_result <= r_acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_stack_ctrl.sv
// Directed bench for fib_stack_ctrl with a behavioral 8-deep stack model.
module tb_fib_stack_ctrl;

  localparam int RES_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       n;
  logic             push;
  logic             pop;
  logic [2:0]       stk_din;
  logic [2:0]       stk_dout;
  logic             stk_empty;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;

  int checks   = 0;
  int failures = 0;
  int sp       = 0;
  int done_cnt = 0;
  logic [2:0] mem [8];

  fib_stack_ctrl #(.RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .push(push), .pop(pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  assign stk_empty = (sp == 0);

  // Stack model: registered read data, combinational empty flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= 0;
      stk_dout <= 3'd0;
    end else if (push) begin
      if (sp < 8) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (pop) begin
      if (sp > 0) begin
        stk_dout <= mem[sp-1];
        sp       <= sp - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every cycle: never push and pop together, never push onto 7 entries.
  always @(negedge clk) begin
    if (!rst) begin
      check("push_and_pop", int'(push && pop), 0);
      check("push_at_depth7", int'(push && sp >= 7), 0);
    end
  end

  // Runs one computation starting in the current (IDLE) cycle.
  task automatic run_fib(input string tag, input logic [2:0] nv, input int exp_res,
                         input int hold_exp, input bit poke, input int exp_lat);
    int lat;
    int d0;
    start = 1'b1;
    n     = nv;
    @(posedge clk); #1;
    start = 1'b0;
    d0    = done_cnt;
    lat   = 1;
    check({tag, "_busy"}, int'(busy), 1);
    while (!done && lat < 400) begin
      if (poke && lat == 3) begin
        start = 1'b1;
        n     = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (hold_exp >= 0 && lat == 3) check({tag, "_hold"}, int'(result), hold_exp);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, int'(lat < 400), 1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, int'(result), exp_res);
    check({tag, "_stack_empty"}, sp, 0);
    @(posedge clk); #1;
    $display("run %s n=%0d result=%0d cycles=%0d", tag, nv, result, lat);
    check({tag, "_done_cleared"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_result_held"}, int'(result), exp_res);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    n     = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_push", int'(push), 0);
    check("rst_pop", int'(pop), 0);
    check("rst_din", int'(stk_din), 0);
    check("rst_result", int'(result), 0);
    rst = 1'b0;

    run_fib("n0", 3'd0, 0, -1, 1'b0, 5);
    run_fib("n1", 3'd1, 1, -1, 1'b0, 5);
    run_fib("n2", 3'd2, 1, -1, 1'b0, 0);
    run_fib("n5", 3'd5, 5, -1, 1'b0, 0);
    run_fib("n7", 3'd7, 13, -1, 1'b0, 0);
    run_fib("b2b6", 3'd6, 8, -1, 1'b0, 0);
    run_fib("b2b3", 3'd3, 2, 8, 1'b0, 0);
    run_fib("poke4", 3'd4, 3, 2, 1'b1, 0);

    // Reset while the controller sits in WAIT during an n=7 run.
    begin
      int cyc;
      start = 1'b1;
      n     = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 0;
      while (!pop && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rst_mid_pop_seen", int'(pop), 1);
      @(posedge clk); #1;
      check("rst_mid_in_wait_push", int'(push), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_push", int'(push), 0);
      check("rst_mid_pop", int'(pop), 0);
      check("rst_mid_done", int'(done), 0);
      check("rst_mid_din", int'(stk_din), 0);
      check("rst_mid_result", int'(result), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset applied mid-run, outputs cleared");
    end

    run_fib("post_rst3", 3'd3, 2, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
